// File: rtl/vend_ctrl.sv
// Vending-machine transaction controller: edge-detects coin/selection/account levels,
// keeps credit in half-yuan units and sequences dispense and change. Optional macro: VEND_REFUND_TIMEOUT_EN.
module vend_ctrl #(
   parameter int unsigned PRICE_COLA  = 5,
   parameter int unsigned PRICE_TEA   = 3,
   parameter int unsigned PRICE_MILK  = 4,
   parameter int unsigned CREDIT_W    = 5,
   parameter int unsigned MAX_CREDIT  = 20,
   parameter int unsigned DISP_CYCLES = 4
`ifdef VEND_REFUND_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT     = 1000
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_half,
   input  logic                coin_one,
   input  logic                sell_cola,
   input  logic                sell_tea,
   input  logic                sell_milk,
   input  logic                account,
   output logic [CREDIT_W-1:0] credit,
   output logic                dispense_cola,
   output logic                dispense_tea,
   output logic                dispense_milk,
   output logic                change_half,
   output logic                coin_reject,
   output logic                insufficient,
   output logic                busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CREDIT = 2'd1,
      S_VEND   = 2'd2,
      S_CHANGE = 2'd3
   } state_e;

   localparam int unsigned WIDE = CREDIT_W + 1;
   localparam int unsigned DCW  = $clog2(DISP_CYCLES + 1);

   localparam logic [CREDIT_W:0] P_COLA    = WIDE'(PRICE_COLA);
   localparam logic [CREDIT_W:0] P_TEA     = WIDE'(PRICE_TEA);
   localparam logic [CREDIT_W:0] P_MILK    = WIDE'(PRICE_MILK);
   localparam logic [CREDIT_W:0] MAX_W     = WIDE'(MAX_CREDIT);
   localparam logic [DCW-1:0]    DISP_LAST = DCW'(DISP_CYCLES - 1);

`ifdef VEND_REFUND_TIMEOUT_EN
   localparam int unsigned       TOW     = $clog2(TIMEOUT + 1);
   localparam logic [TOW-1:0]    TO_LAST = TOW'(TIMEOUT - 1);
   logic [TOW-1:0]               idle_cnt_q;
`endif

   state_e              state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic [DCW-1:0]      disp_cnt_q;
   logic [5:0]          in_q;
   logic                armed_q;
   logic                dispense_cola_q, dispense_tea_q, dispense_milk_q;
   logic                change_half_q, coin_reject_q, insufficient_q, busy_q;

   logic [5:0]          in_now, ev;
   logic                coin_half_ev, coin_one_ev, coin_ev;
   logic                cola_ev, tea_ev, milk_ev, sel_ev, acct_ev;
   logic [CREDIT_W:0]   coin_val_d, sum_d, price_d, diff_d;
   logic                coin_fits, afford;

   // armed_q masks the first cycle after reset so a level already high at release is not an event.
   assign in_now = {account, sell_milk, sell_tea, sell_cola, coin_one, coin_half};
   assign ev     = armed_q ? (in_now & ~in_q) : 6'b0;

   assign coin_half_ev = ev[0];
   assign coin_one_ev  = ev[1];
   assign cola_ev      = ev[2];
   assign tea_ev       = ev[3];
   assign milk_ev      = ev[4];
   assign acct_ev      = ev[5];
   assign coin_ev      = coin_half_ev | coin_one_ev;
   assign sel_ev       = cola_ev | tea_ev | milk_ev;

   always_comb begin
      coin_val_d = WIDE'({coin_one_ev, coin_half_ev});
      sum_d      = {1'b0, credit_q} + coin_val_d;
      coin_fits  = (sum_d <= MAX_W);
      if (cola_ev)     price_d = P_COLA;
      else if (tea_ev) price_d = P_TEA;
      else             price_d = P_MILK;
      // A borrow out of the extra bit means the price exceeds the credit.
      diff_d     = {1'b0, credit_q} - price_d;
      afford     = ~diff_d[CREDIT_W];
   end

   // NOTE: every register here uses <= so all branches see the pre-edge values of the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         credit_q        <= '0;
         disp_cnt_q      <= '0;
         in_q            <= '0;
         armed_q         <= 1'b0;
         dispense_cola_q <= 1'b0;
         dispense_tea_q  <= 1'b0;
         dispense_milk_q <= 1'b0;
         change_half_q   <= 1'b0;
         coin_reject_q   <= 1'b0;
         insufficient_q  <= 1'b0;
         busy_q          <= 1'b0;
`ifdef VEND_REFUND_TIMEOUT_EN
         idle_cnt_q      <= '0;
`endif
      end else begin
         in_q           <= in_now;
         armed_q        <= 1'b1;
         change_half_q  <= 1'b0;
         coin_reject_q  <= 1'b0;
         insufficient_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (coin_ev) begin
                  if (coin_fits) begin
                     credit_q <= sum_d[CREDIT_W-1:0];
                     state_q  <= S_CREDIT;
                  end else begin
                     coin_reject_q <= 1'b1;
                  end
               end
            end

            S_CREDIT: begin
               if (acct_ev) begin
                  coin_reject_q <= coin_ev;
                  state_q       <= S_CHANGE;
                  busy_q        <= 1'b1;
               end else if (sel_ev) begin
                  coin_reject_q <= coin_ev;
                  if (afford) begin
                     credit_q        <= diff_d[CREDIT_W-1:0];
                     state_q         <= S_VEND;
                     busy_q          <= 1'b1;
                     disp_cnt_q      <= '0;
                     dispense_cola_q <= cola_ev;
                     dispense_tea_q  <= ~cola_ev & tea_ev;
                     dispense_milk_q <= ~cola_ev & ~tea_ev;
                  end else begin
                     insufficient_q <= 1'b1;
                  end
               end else if (coin_ev) begin
                  if (coin_fits) credit_q      <= sum_d[CREDIT_W-1:0];
                  else           coin_reject_q <= 1'b1;
               end
`ifdef VEND_REFUND_TIMEOUT_EN
               if (acct_ev || sel_ev || coin_ev) begin
                  idle_cnt_q <= '0;
               end else if (idle_cnt_q == TO_LAST) begin
                  idle_cnt_q <= '0;
                  state_q    <= S_CHANGE;
                  busy_q     <= 1'b1;
               end else begin
                  idle_cnt_q <= idle_cnt_q + TOW'(1);
               end
`endif
            end

            S_VEND: begin
               coin_reject_q <= coin_ev;
               if (disp_cnt_q == DISP_LAST) begin
                  dispense_cola_q <= 1'b0;
                  dispense_tea_q  <= 1'b0;
                  dispense_milk_q <= 1'b0;
                  busy_q          <= 1'b0;
                  state_q         <= (credit_q != '0) ? S_CREDIT : S_IDLE;
               end else begin
                  disp_cnt_q <= disp_cnt_q + DCW'(1);
               end
            end

            S_CHANGE: begin
               coin_reject_q <= coin_ev;
               // Pulse only when the previous cycle was quiet, giving the 1,0,1,0 cadence.
               if (!change_half_q) begin
                  if (credit_q == '0) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     change_half_q <= 1'b1;
                     credit_q      <= credit_q - CREDIT_W'(1);
                     if (credit_q == CREDIT_W'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign credit        = credit_q;
   assign dispense_cola = dispense_cola_q;
   assign dispense_tea  = dispense_tea_q;
   assign dispense_milk = dispense_milk_q;
   assign change_half   = change_half_q;
   assign coin_reject   = coin_reject_q;
   assign insufficient  = insufficient_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl (default build): coins, purchase, refusal, change, ceiling, priority.
module tb_vend_ctrl;

   localparam logic [5:0] B_HALF = 6'b000001;
   localparam logic [5:0] B_ONE  = 6'b000010;
   localparam logic [5:0] B_COLA = 6'b000100;
   localparam logic [5:0] B_TEA  = 6'b001000;
   localparam logic [5:0] B_MILK = 6'b010000;
   localparam logic [5:0] B_ACCT = 6'b100000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] btn = '0;
   logic [4:0] credit;
   logic       dispense_cola, dispense_tea, dispense_milk;
   logic       change_half, coin_reject, insufficient, busy;

   int passed = 0;
   int total  = 0;
   int pulses;

   vend_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_half    (btn[0]),
      .coin_one     (btn[1]),
      .sell_cola    (btn[2]),
      .sell_tea     (btn[3]),
      .sell_milk    (btn[4]),
      .account      (btn[5]),
      .credit       (credit),
      .dispense_cola(dispense_cola),
      .dispense_tea (dispense_tea),
      .dispense_milk(dispense_milk),
      .change_half  (change_half),
      .coin_reject  (coin_reject),
      .insufficient (insufficient),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [5:0] m);
      btn = m;
      tick();
   endtask

   task automatic add_coin(input logic [5:0] m);
      press(m);
      btn = '0;
      tick();
   endtask

   initial begin
      logic       exp_chg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [4:0] exp_cr  [6] = '{5'd2, 5'd2, 5'd1, 5'd1, 5'd0, 5'd0};
      logic       exp_bsy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset with coin_one already high: its level at release must not count.
      rst_n = 1'b0;
      btn   = B_ONE;
      repeat (3) tick();
      check("reset_credit", credit, 0);
      check("reset_outputs", {dispense_cola, dispense_tea, dispense_milk,
                              change_half, coin_reject, insufficient, busy}, 0);
      rst_n = 1'b1;
      repeat (2) tick();
      check("no_event_at_release", credit, 0);
      btn = '0;
      tick();

      // Coin handling and level hold.
      press(B_HALF);
      check("coin_half_adds_1", credit, 1);
      btn = '0;
      press(B_ONE);
      check("coin_one_adds_2", credit, 3);
      repeat (9) tick();
      check("held_coin_counts_once", credit, 3);
      btn = '0;
      tick();
      add_coin(B_ONE);
      add_coin(B_HALF);
      check("credit_6", credit, 6);

      // Cola purchase, with a coin refused mid-dispense.
      press(B_COLA);
      btn = '0;
      check("cola_credit_after", credit, 1);
      check("cola_strobe_c0", dispense_cola, 1);
      check("cola_busy", busy, 1);
      for (int i = 1; i < 4; i++) begin
         btn = (i == 1) ? B_HALF : 6'b0;
         tick();
         check("cola_strobe_held", dispense_cola, 1);
         if (i == 1) begin
            check("vend_coin_reject", coin_reject, 1);
            check("vend_coin_credit", credit, 1);
         end
      end
      tick();
      check("cola_strobe_end", dispense_cola, 0);
      check("cola_busy_end", busy, 0);
      check("cola_credit_kept", credit, 1);

      // Refused selection.
      add_coin(B_HALF);
      press(B_TEA);
      btn = '0;
      check("tea_insufficient", insufficient, 1);
      check("tea_credit_kept", credit, 2);
      check("tea_no_dispense", dispense_tea, 0);
      tick();
      check("insufficient_one_cycle", insufficient, 0);

      // Change return of 3.
      add_coin(B_HALF);
      press(B_ACCT);
      btn = '0;
      check("change_entry_busy", busy, 1);
      check("change_entry_no_pulse", change_half, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("change_pulse", change_half, exp_chg[i]);
         check("change_credit", credit, exp_cr[i]);
         check("change_busy", busy, exp_bsy[i]);
      end

      // Credit ceiling and same-cycle double coin.
      repeat (5) add_coin(B_ONE);
      check("credit_10", credit, 10);
      press(B_HALF | B_ONE);
      check("both_coins_add_3", credit, 13);
      btn = '0;
      tick();
      repeat (3) add_coin(B_ONE);
      check("credit_19", credit, 19);
      press(B_ONE);
      check("ceiling_reject", coin_reject, 1);
      check("ceiling_credit_kept", credit, 19);
      btn = '0;
      tick();
      press(B_HALF);
      check("reach_max_accepted", credit, 20);
      check("reach_max_no_reject", coin_reject, 0);
      btn = '0;
      tick();
      press(B_HALF);
      check("above_max_reject", coin_reject, 1);
      check("above_max_credit", credit, 20);
      btn = '0;
      tick();

      // Drain 20 half-yuan of change within a bounded window.
      press(B_ACCT);
      btn    = '0;
      pulses = 0;
      repeat (60) begin
         tick();
         if (change_half) pulses++;
      end
      check("drain_pulse_count", pulses, 20);
      check("drain_credit", credit, 0);
      check("drain_busy", busy, 0);

      // Simultaneous cola + milk at credit 5.
      add_coin(B_ONE);
      add_coin(B_ONE);
      add_coin(B_HALF);
      press(B_COLA | B_MILK);
      btn = '0;
      check("prio_cola", dispense_cola, 1);
      check("prio_no_milk", dispense_milk, 0);
      check("prio_credit_0", credit, 0);
      repeat (4) tick();
      check("prio_strobe_end", dispense_cola, 0);
      check("prio_busy_end", busy, 0);
      press(B_TEA);
      btn = '0;
      check("idle_ignores_select", insufficient, 0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
